serial_compare_arbiter: RTL
===========================

# serial_compare_arbiter

Shares one bit-serial magnitude comparator between NREQ requesters. Arbitrates round-robin, loads the winner's operand pair, and sequences the MSB-first serial compare one bit per clock, stopping early at the first differing bit. Returns a one-hot less/equal/greater result tagged with the requester ID over a valid/ready handshake. Sits between the requesting datapath blocks and the serialized comparison engine.

## Interface
- WIDTH, 4, operand width in bits (>= 2)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), requester ID width (derived, not overridden)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  requester that owns the result
- rsp_lt, rsp_eq, rsp_gt  out  1 each  one-hot result, unsigned A vs B
- rsp_bits  out  $clog2(WIDTH+1)  bit positions examined (1..WIDTH)
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: among asserted req_valid bits, grant the first at or after the round-robin pointer, wrapping from NREQ-1 to 0. req_ready[grant] is combinational from req_valid and the pointer, and only in IDLE. If no req_valid, req_ready = 0.
- Accept on req_valid[g] && req_ready[g]:
  - capture req_a/req_b slices into shift registers and g into the ID register;
  - clear the bit counter;
  - set the pointer to (g+1) mod NREQ;
  - go to SHIFT.
- SHIFT: each cycle compares the MSBs of the shift registers and increments the counter.
  - MSBs differ: latch lt = b_msb, gt = a_msb, eq = 0, then go to DONE.
  - MSBs equal and counter = WIDTH-1: latch eq = 1, then go to DONE.
  - Otherwise shift both registers left by 1 and stay in SHIFT.
- DONE: rsp_valid = 1. rsp_id, rsp_lt/eq/gt and rsp_bits are held stable until rsp_valid && rsp_ready. Then go to IDLE.
- Operands are unsigned. Changes on req_a/req_b after acceptance have no effect.
- Reset (async, any state):
  - state = IDLE, pointer = 0;
  - all outputs 0, including rsp_lt/eq/gt = 000;
  - an in-flight comparison is discarded with no response.

## Timing
- Latency: let k = MSB-first index of the first differing bit, or WIDTH-1 if the operands are equal.
  - rsp_valid rises in the cycle after the (k+1)-th rising edge following the accept edge.
  - Minimum 1 cycle in SHIFT; maximum WIDTH cycles.
- rsp_bits = k+1.
- At least one IDLE cycle separates a response handshake from the next accept. Throughput is at most one comparison per (k+3) cycles.
- rsp_ready high on the DONE-entry cycle completes the handshake that cycle.
- A requester that drops req_valid before being granted loses nothing; no request state is stored.
- Simultaneous requests: exactly one grant per IDLE cycle.
- Starvation-free: a continuously valid requester is granted within NREQ accepts.
- Reset deassertion: first possible accept is the first rising edge with reset_n high.

## Structure
- Package serial_cmp_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - 3-bit result encoding constants RES_LT = 100, RES_EQ = 010, RES_GT = 001, ordered {lt, eq, gt}.
- Sub-module serial_cmp_core:
  - inputs: load, operands, shift enable;
  - outputs: MSB-difference flag, last-bit flag, latched result, bit count;
  - holds the shift registers and the counter.
- Top level: round-robin arbiter, FSM, operand mux, response register.

## Test plan
- WIDTH=4, single requester 0, A=1010, B=0110, rsp_ready=1: rsp_gt=1, rsp_bits=1, rsp_valid 1 cycle after the accept edge, rsp_id=0.
- A=0101, B=0101: rsp_eq=1, rsp_bits=4, rsp_valid 4 cycles after accept. A=0100, B=0101: rsp_lt=1, rsp_bits=4.
- NREQ=4, all req_valid held high, rsp_ready=1: grant order 0,1,2,3,0. Only one req_ready bit is high in any cycle, and only in IDLE.
- rsp_ready low for 5 cycles in DONE: rsp_valid and all result fields hold their values, no new req_ready, busy=1. Raise rsp_ready: handshake completes, then IDLE.
- Assert reset_n=0 mid-SHIFT, away from any clock edge: outputs go to 0 immediately. After release, the pointer is 0 and no stale response appears.
- Requester 2 changes req_a the cycle after its accept: the result reflects the captured operands only.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and result encodings for the serial compare arbiter.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Result ordering is {lt, eq, gt}.
   localparam logic [2:0] RES_LT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_GT = 3'b001;

   function automatic logic [2:0] msb_result(input logic a_msb, input logic b_msb);
      if (a_msb == b_msb) return RES_EQ;
      return a_msb ? RES_GT : RES_LT;
   endfunction

endpackage

// File: rtl/serial_cmp_core.sv
// Bit-serial MSB-first magnitude compare engine: operand shift registers plus bit counter.
module serial_cmp_core
   import serial_cmp_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_shift_en,
   output logic             o_msb_diff_c,
   output logic             o_last_c,
   output logic [2:0]       o_res_c,
   output logic [CW-1:0]    o_cnt
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_cnt <= '0;
      end else if (i_shift_en) begin
         r_a   <= {r_a[WIDTH-2:0], 1'b0};
         r_b   <= {r_b[WIDTH-2:0], 1'b0};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_msb_diff_c = r_a[WIDTH-1] ^ r_b[WIDTH-1];
   assign o_last_c     = (r_cnt == CW'(WIDTH - 1));
   assign o_res_c      = msb_result(r_a[WIDTH-1], r_b[WIDTH-1]);
   assign o_cnt        = r_cnt;

endmodule

// File: rtl/serial_compare_arbiter.sv
// Round-robin arbiter sharing one bit-serial comparator across NREQ requesters,
// returning an ID-tagged one-hot lt/eq/gt result over valid/ready.
module serial_compare_arbiter
   import serial_cmp_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   parameter  int unsigned NREQ  = 4,
   localparam int unsigned IDW   = $clog2(NREQ),
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_lt,
   output logic                  rsp_eq,
   output logic                  rsp_gt,
   output logic [CW-1:0]         rsp_bits,
   output logic                  busy
);

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [2:0]       r_res;
   logic [CW-1:0]    r_bits;
   logic             r_rsp_valid;
   logic             r_busy;

   logic             w_found;
   logic [IDW-1:0]   w_grant_id;
   logic [NREQ-1:0]  w_grant_oh;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_load;
   logic             w_shift_en;
   logic             w_msb_diff;
   logic             w_last;
   logic [2:0]       w_res;
   logic [CW-1:0]    w_cnt;

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      int unsigned v_idx;
      v_idx      = 0;
      w_found    = 1'b0;
      w_grant_id = '0;
      w_grant_oh = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         v_idx = 32'(r_ptr) + i;
         if (v_idx >= NREQ) v_idx = v_idx - NREQ;
         if (!w_found && req_valid[v_idx[IDW-1:0]]) begin
            w_found    = 1'b1;
            w_grant_id = v_idx[IDW-1:0];
         end
      end
      if (w_found) w_grant_oh[w_grant_id] = 1'b1;
   end

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_grant_id == IDW'(i)) begin
            w_a = req_a[i*WIDTH +: WIDTH];
            w_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Grant is only offered in IDLE and is forced low while reset is asserted.
   assign req_ready  = (r_state == IDLE && reset_n) ? w_grant_oh : '0;
   assign w_load     = (r_state == IDLE) && w_found;
   assign w_shift_en = (r_state == SHIFT);

   serial_cmp_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_load       (w_load),
      .i_a          (w_a),
      .i_b          (w_b),
      .i_shift_en   (w_shift_en),
      .o_msb_diff_c (w_msb_diff),
      .o_last_c     (w_last),
      .o_res_c      (w_res),
      .o_cnt        (w_cnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_id        <= '0;
         r_res       <= '0;
         r_bits      <= '0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_id    <= w_grant_id;
                  r_ptr   <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_msb_diff || w_last) begin
                  r_res       <= w_res;
                  r_bits      <= w_cnt + CW'(1);
                  r_rsp_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_id;
   assign rsp_lt    = r_res[2];
   assign rsp_eq    = r_res[1];
   assign rsp_gt    = r_res[0];
   assign rsp_bits  = r_bits;
   assign busy      = r_busy;

endmodule
